// File: rtl/scamp_loader_pkg.sv
// Shared types and constants for the mem_loader boot loader.
// The checksum feature is selected with the CHECKSUM_EN macro.
package scamp_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam logic [7:0] ROM_PAGE = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_LEN_HI  = 4'd3,
    ST_LEN_LO  = 4'd4,
    ST_DATA_HI = 4'd5,
    ST_DATA_LO = 4'd6,
    ST_WRITE   = 4'd7,
    ST_CSUM_HI = 4'd8,
    ST_CSUM_LO = 4'd9,
    ST_DONE    = 4'd10
  } state_t;

  function automatic logic in_rom_page(input logic [WORD_W-1:0] a);
    return a[WORD_W-1:BYTE_W] == ROM_PAGE;
  endfunction

endpackage

// File: rtl/mem_loader_byte_pair_assembler.sv
// Holds the high byte of a big-endian pair; the full word is presented
// alongside the low byte so the owner can capture it on the low-byte edge.
module byte_pair_assembler
  import scamp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              take_hi,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_W-1:0] hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
    end else if (take_hi) begin
      hi <= byte_in;
    end
  end

  assign word = {hi, byte_in};

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream boot loader that fills RAM one 16-bit word per write cycle.
// Define CHECKSUM_EN to expect and verify a trailing 16-bit payload sum.
module mem_loader
  import scamp_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] address,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic        rom_err,
  output logic        csum_err,
  output logic [3:0]  dbg_state
);

  // Handshake: a byte transfers on a rising edge when in_valid and in_ready
  // are both high; in_ready is registered and never depends on in_valid.

  state_t            state;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] count;
  logic [WORD_W-1:0] word;
  logic              accept;
  logic              take_hi;
`ifdef CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  assign accept    = in_valid & in_ready;
  assign dbg_state = state;

  always_comb begin
    take_hi = 1'b0;
    case (state)
      ST_IDLE, ST_ADDR_HI, ST_LEN_HI, ST_DATA_HI, ST_CSUM_HI: take_hi = accept;
      default: take_hi = 1'b0;
    endcase
  end

  byte_pair_assembler u_pair (
    .clk     (clk),
    .reset   (reset),
    .take_hi (take_hi),
    .byte_in (in_data),
    .word    (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      address  <= '0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_err  <= 1'b0;
      csum_err <= 1'b0;
`ifdef CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      case (state)
        // The idle state doubles as the ADDR_HI receiver.
        ST_IDLE, ST_ADDR_HI: begin
          if (accept) begin
            state    <= ST_ADDR_LO;
            busy     <= 1'b1;
            rom_err  <= 1'b0;
            csum_err <= 1'b0;
          end
        end
        ST_ADDR_LO: begin
          if (accept) begin
            addr  <= word;
            state <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) state <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (accept) begin
            count <= word;
`ifdef CHECKSUM_EN
            sum   <= '0;
`endif
            if (word == '0) begin
`ifdef CHECKSUM_EN
              state    <= ST_CSUM_HI;
`else
              state    <= ST_DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
`endif
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (accept) state <= ST_DATA_LO;
        end
        ST_DATA_LO: begin
          if (accept) begin
            state    <= ST_WRITE;
            in_ready <= 1'b0;
            address  <= addr;
            bus_out  <= word;
            bus_oe   <= 1'b1;
            // ROM-page words are consumed but never strobed into memory.
            if (in_rom_page(addr)) begin
              load    <= 1'b0;
              rom_err <= 1'b1;
            end else begin
              load    <= 1'b1;
            end
`ifdef CHECKSUM_EN
            sum      <= sum + word;
`endif
          end
        end
        ST_WRITE: begin
          bus_oe <= 1'b0;
          load   <= 1'b0;
          addr   <= addr + 16'd1;
          count  <= count - 16'd1;
          if (count != 16'd1) begin
            state    <= ST_DATA_HI;
            in_ready <= 1'b1;
          end else begin
`ifdef CHECKSUM_EN
            state    <= ST_CSUM_HI;
            in_ready <= 1'b1;
`else
            state    <= ST_DONE;
            done     <= 1'b1;
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM_HI: begin
          if (accept) state <= ST_CSUM_LO;
        end
        ST_CSUM_LO: begin
          if (accept) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            in_ready <= 1'b0;
            csum_err <= (word != sum);
          end
        end
`endif
        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          bus_oe   <= 1'b0;
          load     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed and randomized frames for mem_loader, checked against a word-level
// model of the frame format and a bench-side memory array.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] address;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        load;
  logic        busy;
  logic        done;
  logic        rom_err;
  logic        csum_err;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Expected write cycles: {load, address, data}.
  logic [32:0] exp_q[$];
  logic [15:0] frame_words[$];
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .address   (address),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .rom_err   (rom_err),
    .csum_err  (csum_err),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required frames to complete");
    $fatal(1, "watchdog");
  end

  // The memory block captures the bus on the edge that ends the write cycle.
  always @(posedge clk) begin
    if (load === 1'b1) mem[address] <= bus_out;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every bus_oe cycle must match the next expected write.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (bus_oe === 1'b1) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write: observed write %h expected none", {load, address, bus_out});
        end
        if (exp_q.size() != 0) chk("write", {load, address, bus_out}, exp_q.pop_front());
      end else if (load !== 1'b0) begin
        chk("load_without_oe", {32'd0, load}, 33'd0);
      end
    end
  end

  // Driver
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: in_ready observed %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference model: builds the byte stream, expected writes and final flags
  // for frame_words at address a, then drives and checks the whole frame.
  task automatic run_frame(input string tag, input logic [15:0] a, input bit bad_csum,
                           input int max_gap, input int stall);
    logic [7:0]  bq[$];
    logic [15:0] len;
    logic [15:0] s;
    logic [15:0] wa;
    logic        exp_rom;
    logic        exp_cs;
    int          d0;
    int          t;
    len     = 16'(frame_words.size());
    s       = 16'd0;
    exp_rom = 1'b0;
    bq = {a[15:8], a[7:0], len[15:8], len[7:0]};
    for (int i = 0; i < frame_words.size(); i++) begin
      bq.push_back(frame_words[i][15:8]);
      bq.push_back(frame_words[i][7:0]);
      s  = s + frame_words[i];
      wa = a + 16'(i);
      exp_q.push_back({wa[15:8] != 8'h00, wa, frame_words[i]});
      if (wa[15:8] == 8'h00) exp_rom = 1'b1;
      else ref_mem[wa] = frame_words[i];
    end
`ifdef CHECKSUM_EN
    if (bad_csum) s = s + 16'd1;
    bq.push_back(s[15:8]);
    bq.push_back(s[7:0]);
    exp_cs = bad_csum;
`else
    exp_cs = 1'b0;
`endif
    d0 = done_cnt;
    for (int i = 0; i < bq.size(); i++) begin
      if (i == 5 && stall > 0) begin
        repeat (stall) begin
          @(negedge clk);
          chk({tag, "_stall_ready"}, {32'd0, in_ready}, 33'd1);
          chk({tag, "_stall_outs"}, {29'd0, bus_oe, load, done, busy}, 33'b0001);
        end
      end
      send_byte(bq[i], $urandom_range(0, max_gap));
    end
    t = 0;
    while (done_cnt == d0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_pulses"}, 33'(done_cnt - d0), 33'd1);
    chk({tag, "_rom_err"}, {32'd0, rom_err}, {32'd0, exp_rom});
    chk({tag, "_csum_err"}, {32'd0, csum_err}, {32'd0, exp_cs});
    chk({tag, "_idle"}, {31'd0, busy, in_ready}, 33'b01);
    chk({tag, "_writes_left"}, 33'(exp_q.size()), 33'd0);
    for (int i = 0; i < frame_words.size(); i++) begin
      wa = a + 16'(i);
      chk({tag, "_readback"}, {1'b0, wa, mem[wa]}, {1'b0, wa, ref_mem[wa]});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, in_ready, bus_oe, load, busy, done, rom_err, csum_err},
        33'b1000000);
    chk({tag, "_bus"}, {1'b0, address, bus_out}, 33'd0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = (i < 256) ? (16'hC000 | 16'(i)) : 16'h0000;
      ref_mem[i] = mem[i];
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Two words into RAM at 500.
    frame_words = {16'h1ED2, 16'h22CB};
    run_frame("ram2", 16'h01F4, 1'b0, 0, 0);
    chk("ram2_ram500", {17'd0, mem[16'h01F4]}, 33'h1ED2);
    chk("ram2_ram501", {17'd0, mem[16'h01F5]}, 33'h22CB);

    // Single word aimed at the ROM page.
    frame_words = {16'h1234};
    run_frame("rom", 16'h0010, 1'b0, 0, 0);
    chk("rom_unchanged", {17'd0, mem[16'h0010]}, 33'hC010);

    // Address wrap from FFFF into the ROM page.
    frame_words = {16'hAAAA, 16'hBBBB};
    run_frame("wrap", 16'hFFFF, 1'b0, 1, 0);
    chk("wrap_ffff", {17'd0, mem[16'hFFFF]}, 33'hAAAA);
    chk("wrap_0000", {17'd0, mem[16'h0000]}, 33'hC000);

    // Zero-length frame: done in the cycle after LEN_LO.
    d0 = done_cnt;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef CHECKSUM_EN
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`endif
    chk("len0_done_high", {31'd0, done, busy}, 33'b11);
    chk("len0_not_ready", {32'd0, in_ready}, 33'd0);
    @(posedge clk);
    #1;
    chk("len0_done_low", {30'd0, done, busy, in_ready}, 33'b001);
    @(negedge clk);
    #1;
    chk("len0_done_pulses", 33'(done_cnt - d0), 33'd1);
    chk("len0_csum_err", {32'd0, csum_err}, 33'd0);

    // Five-cycle stall between DATA_HI and DATA_LO.
    frame_words = {16'h5AA5, 16'h0F0F};
    run_frame("stall", 16'h2000, 1'b0, 0, 5);

    // Reset in the middle of a payload word.
    frame_words = {16'h1111, 16'h2222};
    exp_q.push_back({1'b0, 16'h00FF, 16'h1111});
    exp_q.push_back({1'b1, 16'h0100, 16'h2222});
    ref_mem[16'h0100] = 16'h2222;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    chk("midrst_before", {31'd0, rom_err, busy}, 33'b11);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_writes_left", 33'(exp_q.size()), 33'd0);
    chk("midrst_ram100", {17'd0, mem[16'h0100]}, 33'h2222);
    chk("midrst_ram101", {17'd0, mem[16'h0101]}, {17'd0, ref_mem[16'h0101]});

    // Randomized frames, some in the ROM page, some with bad checksums.
    for (int f = 0; f < 6; f++) begin
      logic [15:0] a;
      int          n;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {8'h00, 8'($urandom)};
      n = $urandom_range(1, 6);
      frame_words = {};
      for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
      run_frame("rand", a, 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
